// File: rtl/ahb_tl_pkg.sv
// ============================================================================
// ahb_tl_pkg
// Shared AHB-Lite / TileLink-UL encodings and the inbound-bridge FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ahb_tl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] TL_GET           = 3'd4;
  localparam logic [2:0] TL_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_A_SEND = 3'd2,
    ST_D_WAIT = 3'd3,
    ST_RESP   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ahb_tl_mask_gen.sv
// ============================================================================
// ahb_tl_mask_gen
// Byte-lane mask and bad-transfer flag from a transfer size and address offset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_tl_mask_gen (
  input  logic [2:0] size,
  input  logic [1:0] offset,
  output logic [3:0] mask,
  output logic       bad
);

  // bad covers both unsupported sizes and offsets not aligned to the size
  always_comb begin
    mask = 4'b0000;
    bad  = 1'b0;
    case (size)
      3'd0: mask = 4'b0001 << offset;
      3'd1: begin
        mask = offset[1] ? 4'b1100 : 4'b0011;
        bad  = offset[0];
      end
      3'd2: begin
        mask = 4'b1111;
        bad  = |offset;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ahb_lite_to_tl_ul_bridge.sv
// ============================================================================
// ahb_lite_to_tl_ul_bridge
// Inbound AHB-Lite subordinate reissuing single beats as TL-UL Get/Put requests.
// Optional macro AHB_TL_BRIDGE_POSTED_WRITE_EN makes writes posted.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_lite_to_tl_ul_bridge
  import ahb_tl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SRC_W  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hsel,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [31:0]       hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [2:0]        a_size,
  output logic [SRC_W-1:0]  a_source,
  output logic [ADDR_W-1:0] a_address,
  output logic [3:0]        a_mask,
  output logic [31:0]       a_data,
  input  logic              d_valid,
  input  logic              d_denied,
  input  logic              d_corrupt,
  input  logic [2:0]        d_opcode,
  input  logic [31:0]       d_data,
  output logic              d_ready,
  output logic              posted_err
);

`ifdef AHB_TL_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_e              state_q, state_d;
  logic                txn_write_q, txn_write_d;
  logic [ADDR_W-1:0]   txn_addr_q, txn_addr_d;
  logic [2:0]          txn_size_q, txn_size_d;
  logic [3:0]          txn_mask_q, txn_mask_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         hrdata_q, hrdata_d;
  logic                pend_q, pend_d;
  logic                pend_write_q, pend_write_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [2:0]          pend_size_q, pend_size_d;
  logic                posted_err_q, posted_err_d;

  logic                bg;
  logic                accept;
  logic                do_launch;
  logic                l_write;
  logic [ADDR_W-1:0]   l_addr;
  logic [2:0]          l_size;
  logic [3:0]          l_mask;
  logic                l_bad;
  logic                unused_sigs;

  assign unused_sigs = ^{hburst, hprot, d_opcode};

  // A posted write keeps the AHB side open while its Put is still in flight
  assign bg = POSTED && txn_write_q &&
              (state_q == ST_WDATA || state_q == ST_A_SEND || state_q == ST_D_WAIT);

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      ST_WDATA:             hreadyout = POSTED;
      ST_A_SEND, ST_D_WAIT: hreadyout = bg & ~pend_q;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2:              hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign accept = hsel & hreadyin & htrans[1] & hreadyout & (state_q != ST_ERR2);

  // A held transfer takes priority over the live bus when a new beat launches
  assign l_write = pend_q ? pend_write_q : hwrite;
  assign l_addr  = pend_q ? pend_addr_q  : haddr;
  assign l_size  = pend_q ? pend_size_q  : hsize;

  ahb_tl_mask_gen u_mask_gen (
    .size   (l_size),
    .offset (l_addr[1:0]),
    .mask   (l_mask),
    .bad    (l_bad)
  );

  always_comb begin
    state_d      = state_q;
    txn_write_d  = txn_write_q;
    txn_addr_d   = txn_addr_q;
    txn_size_d   = txn_size_q;
    txn_mask_d   = txn_mask_q;
    wdata_d      = wdata_q;
    hrdata_d     = hrdata_q;
    pend_d       = pend_q;
    pend_write_d = pend_write_q;
    pend_addr_d  = pend_addr_q;
    pend_size_d  = pend_size_q;
    posted_err_d = posted_err_q;
    do_launch    = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d   = ST_IDLE;
        do_launch = accept;
      end
      ST_WDATA: begin
        wdata_d = hwdata;
        state_d = ST_A_SEND;
      end
      ST_A_SEND: if (a_ready) state_d = ST_D_WAIT;
      ST_D_WAIT: if (d_valid) begin
        if (bg) begin
          posted_err_d = posted_err_q | d_denied;
          state_d      = ST_IDLE;
          do_launch    = pend_q | accept;
          pend_d       = 1'b0;
        end else if (d_denied || (d_corrupt && !txn_write_q)) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_RESP;
          if (!txn_write_q) hrdata_d = d_data;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bg && accept && !(state_q == ST_D_WAIT && d_valid)) begin
      pend_d       = 1'b1;
      pend_write_d = hwrite;
      pend_addr_d  = haddr;
      pend_size_d  = hsize;
    end

    if (do_launch) begin
      txn_write_d = l_write;
      txn_addr_d  = l_addr;
      txn_size_d  = l_size;
      txn_mask_d  = l_mask;
      if (l_bad)        state_d = ST_ERR1;
      else if (l_write) state_d = ST_WDATA;
      else              state_d = ST_A_SEND;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      txn_write_q  <= 1'b0;
      txn_addr_q   <= '0;
      txn_size_q   <= 3'd0;
      txn_mask_q   <= 4'd0;
      wdata_q      <= 32'd0;
      hrdata_q     <= 32'd0;
      pend_q       <= 1'b0;
      pend_write_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_size_q  <= 3'd0;
      posted_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      txn_write_q  <= txn_write_d;
      txn_addr_q   <= txn_addr_d;
      txn_size_q   <= txn_size_d;
      txn_mask_q   <= txn_mask_d;
      wdata_q      <= wdata_d;
      hrdata_q     <= hrdata_d;
      pend_q       <= pend_d;
      pend_write_q <= pend_write_d;
      pend_addr_q  <= pend_addr_d;
      pend_size_q  <= pend_size_d;
      posted_err_q <= posted_err_d;
    end
  end

  // A-channel fields read as zero whenever no request is being offered
  assign a_valid   = (state_q == ST_A_SEND);
  assign a_opcode  = !a_valid    ? 3'd0 :
                     !txn_write_q ? TL_GET :
                     (txn_size_q == HSIZE_WORD) ? TL_PUTFULL : TL_PUTPARTIAL;
  assign a_param   = 3'd0;
  assign a_size    = a_valid ? txn_size_q : 3'd0;
  assign a_source  = '0;
  assign a_address = a_valid ? txn_addr_q : '0;
  assign a_mask    = a_valid ? txn_mask_q : 4'd0;
  assign a_data    = (a_valid && txn_write_q) ? wdata_q : 32'd0;
  assign d_ready   = (state_q == ST_D_WAIT);
  assign hrdata    = hrdata_q;
  assign posted_err = POSTED & posted_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_to_tl_ul_bridge.sv
// ============================================================================
// tb_ahb_lite_to_tl_ul_bridge
// Table vectors, directed corner sequences and random transfers vs a TL model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_lite_to_tl_ul_bridge;

`ifdef AHB_TL_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clock, reset;
  logic        hsel, hwrite, hreadyin;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [0:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_denied, d_corrupt;
  logic [2:0]  d_opcode;
  logic [31:0] d_data;
  logic        d_ready, posted_err;

  int total = 0;
  int bad   = 0;

  ahb_lite_to_tl_ul_bridge #(.ADDR_W(32), .SRC_W(1)) dut (
    .clock(clock), .reset(reset), .hsel(hsel), .hwrite(hwrite), .hreadyin(hreadyin),
    .haddr(haddr), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_opcode(d_opcode), .d_data(d_data), .d_ready(d_ready), .posted_err(posted_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          done;
    bit          err;
    int          cycles;
    bit          a_seen;
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [0:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] rdata;
    bit          stable;
    bit          stall_ok;
    bit          err_seq_ok;
  } res_t;

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          aw;
    int          dw;
    bit          den;
    bit          cor;
    logic [31:0] dd;
    bit          e_err;
    int          e_cyc;
    bit          e_a;
    logic [2:0]  e_op;
    logic [3:0]  e_mask;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  // One AHB transfer starting in a cycle where hreadyout=1, with a TL responder
  task automatic xfer(input bit w, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, input int aw, input int dw,
                      input bit den, input bit cor, input logic [31:0] dd,
                      output res_t r);
    int acnt, dcnt;
    bit ahb_done, d_done, a_prev, ar_prev, saw_err1;
    r = '{default: 0};
    r.stable = 1; r.stall_ok = 1;
    acnt = 0; dcnt = 0; ahb_done = 0; d_done = 0; a_prev = 0; ar_prev = 0; saw_err1 = 0;
    hsel = 1'b1; hreadyin = 1'b1; htrans = 2'b10; haddr = addr; hwrite = w; hsize = sz;
    hburst = 3'($urandom); hprot = 4'($urandom);
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 1) begin
        bus_idle();
        hwdata = wd;
        haddr  = $urandom;
      end
      if (d_valid) d_done = 1;
      a_ready = 1'b0; d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
      if (!ahb_done) begin
        if (hresp && !hreadyout) saw_err1 = 1;
        if (!(POSTED && w) && (a_valid || d_ready) && hreadyout) r.stall_ok = 0;
        if (hreadyout) begin
          ahb_done = 1; r.cycles = c; r.err = hresp; r.rdata = hrdata;
          r.err_seq_ok = !hresp || saw_err1;
        end
      end
      if (a_prev && ar_prev && a_valid) r.stable = 0;  // handshake must retire the beat
      if (a_valid) begin
        if (!r.a_seen) begin
          r.a_seen = 1; r.op = a_opcode; r.param = a_param; r.size = a_size;
          r.src = a_source; r.addr = a_address; r.mask = a_mask; r.data = a_data;
        end else if ({a_opcode, a_size, a_address, a_mask, a_data} !==
                     {r.op, r.size, r.addr, r.mask, r.data}) begin
          r.stable = 0;
        end
        a_ready = (acnt >= aw);
        acnt++;
      end
      a_prev = a_valid; ar_prev = a_ready;
      if (d_ready && !d_done) begin
        if (dcnt >= dw) begin
          d_valid = 1'b1; d_data = dd; d_denied = den; d_corrupt = cor;
          d_opcode = w ? 3'd0 : 3'd1;
        end
        dcnt++;
      end
      if (ahb_done && (d_done || !(POSTED && w) || r.err)) begin
        r.done = 1;
        break;
      end
    end
  endtask

  // Reference model: transfer rules computed directly from size/offset arithmetic
  function automatic bit ref_bad(logic [31:0] addr, logic [2:0] sz);
    if (sz > 3'd2) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] ref_mask(logic [31:0] addr, logic [2:0] sz);
    int nb;
    int m;
    nb = 1 << sz;
    m  = ((1 << nb) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic int ref_cyc(bit w, bit bd, bit tl_err, int aw, int dw);
    if (bd) return 2;
    if (w && POSTED) return 1;
    return (w ? 4 : 3) + aw + dw + (tl_err ? 1 : 0);
  endfunction

  task automatic check_res(input string tag, input res_t r, input bit w, input logic [31:0] addr,
                           input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] dd,
                           input bit e_err, input int e_cyc, input bit e_a,
                           input logic [2:0] e_op, input logic [3:0] e_mask);
    chk({tag, "_done"},   32'(r.done), 32'd1);
    chk({tag, "_err"},    32'(r.err), 32'(e_err));
    chk({tag, "_cycles"}, 32'(r.cycles), 32'(e_cyc));
    chk({tag, "_a_seen"}, 32'(r.a_seen), 32'(e_a));
    chk({tag, "_stall"},  32'(r.stall_ok), 32'd1);
    if (e_err) chk({tag, "_errseq"}, 32'(r.err_seq_ok), 32'd1);
    if (e_a) begin
      chk({tag, "_op"},     32'(r.op), 32'(e_op));
      chk({tag, "_mask"},   32'(r.mask), 32'(e_mask));
      chk({tag, "_size"},   32'(r.size), 32'(sz));
      chk({tag, "_addr"},   r.addr, addr);
      chk({tag, "_param"},  32'({r.param, r.src}), 32'd0);
      chk({tag, "_stable"}, 32'(r.stable), 32'd1);
      if (w) chk({tag, "_wdata"}, r.data, wd);
    end
    if (!w && !e_err) chk({tag, "_rdata"}, r.rdata, dd);
  endtask

  vec_t tab[13];
  res_t r;
  int   wr_ok;

  initial begin
    wr_ok = POSTED ? 1 : 4;
    //            w  addr          sz    wd            aw dw den cor dd            err         cyc                       a  op    mask
    tab[0]  = '{0, 32'h2000_0004, 3'd2, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 0,          3,                        1, 3'd4, 4'hF};
    tab[1]  = '{1, 32'h2000_0002, 3'd0, 32'h00AB0000, 0, 0, 0, 0, 32'h0,        0,          wr_ok,                    1, 3'd1, 4'b0100};
    tab[2]  = '{0, 32'h2000_0001, 3'd1, 32'h0,        0, 0, 0, 0, 32'h0,        1,          2,                        0, 3'd0, 4'h0};
    tab[3]  = '{0, 32'h2000_0010, 3'd2, 32'h0,        5, 0, 0, 0, 32'hCAFEF00D, 0,          8,                        1, 3'd4, 4'hF};
    tab[4]  = '{0, 32'h2000_0014, 3'd2, 32'h0,        0, 0, 1, 0, 32'h12121212, 1,          4,                        1, 3'd4, 4'hF};
    tab[5]  = '{1, 32'h2000_0008, 3'd2, 32'h12345678, 0, 2, 0, 0, 32'h0,        0,          POSTED ? 1 : 6,           1, 3'd0, 4'hF};
    tab[6]  = '{0, 32'h2000_0018, 3'd2, 32'h0,        0, 1, 0, 1, 32'h77777777, 1,          5,                        1, 3'd4, 4'hF};
    tab[7]  = '{1, 32'h2000_001A, 3'd1, 32'h5A5A0000, 0, 0, 0, 1, 32'h0,        0,          wr_ok,                    1, 3'd1, 4'b1100};
    tab[8]  = '{0, 32'h2000_0000, 3'd3, 32'h0,        0, 0, 0, 0, 32'h0,        1,          2,                        0, 3'd0, 4'h0};
    tab[9]  = '{1, 32'h2000_0020, 3'd2, 32'hFEEDFACE, 0, 0, 1, 0, 32'h0,        !POSTED,    POSTED ? 1 : 5,           1, 3'd0, 4'hF};
    tab[10] = '{0, 32'h2000_0023, 3'd0, 32'h0,        0, 0, 0, 0, 32'h11223344, 0,          3,                        1, 3'd4, 4'b1000};
    tab[11] = '{1, 32'h2000_000E, 3'd1, 32'hAAAA0000, 2, 0, 0, 0, 32'h0,        0,          POSTED ? 1 : 6,           1, 3'd1, 4'b1100};
    tab[12] = '{1, 32'h2000_0006, 3'd2, 32'h0,        0, 0, 0, 0, 32'h0,        1,          2,                        0, 3'd0, 4'h0};

    reset = 1'b1; hreadyin = 1'b1; bus_idle(); haddr = 0; hsize = 0; hburst = 0; hprot = 0;
    hwdata = 0; a_ready = 0; d_valid = 0; d_denied = 0; d_corrupt = 0; d_opcode = 0; d_data = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp",     32'(hresp), 32'd0);
    chk("rst_hrdata",    hrdata, 32'd0);
    chk("rst_a_fields",  32'({a_valid, a_opcode, a_size, a_mask, a_param}), 32'd0);
    chk("rst_a_addr",    a_address, 32'd0);
    chk("rst_d_ready",   32'(d_ready), 32'd0);
    chk("rst_posted_err", 32'(posted_err), 32'd0);

    // IDLE and BUSY transfers: zero-wait OKAY, no TL traffic
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h2000_0000; hsize = 3'd2;
    tick();
    chk("busy_ready", 32'({hreadyout, hresp, a_valid}), 32'b100);
    htrans = 2'b00;
    tick();
    chk("idle_ready", 32'({hreadyout, hresp, a_valid}), 32'b100);
    bus_idle();
    tick();

    for (int i = 0; i < 13; i++) begin
      xfer(tab[i].w, tab[i].addr, tab[i].sz, tab[i].wd, tab[i].aw, tab[i].dw,
           tab[i].den, tab[i].cor, tab[i].dd, r);
      check_res($sformatf("vec%0d", i), r, tab[i].w, tab[i].addr, tab[i].sz, tab[i].wd,
                tab[i].dd, tab[i].e_err, tab[i].e_cyc, tab[i].e_a, tab[i].e_op, tab[i].e_mask);
      tick();
    end
`ifndef AHB_TL_BRIDGE_POSTED_WRITE_EN
    chk("posted_err_tied", 32'(posted_err), 32'd0);
`endif

    // Transfer presented in ERR2 must be ignored
    xfer(0, 32'h2000_0003, 3'd2, 0, 0, 0, 0, 0, 0, r);
    chk("err2_resp", 32'({r.done, r.err}), 32'b11);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h2000_0004; hsize = 3'd2;
    tick();
    bus_idle();
    chk("err2_ignored", 32'({hreadyout, a_valid}), 32'b10);
    tick();

    // Back-to-back reads, second one accepted in the RESP cycle
    xfer(0, 32'h2000_0030, 3'd2, 0, 0, 0, 0, 0, 32'hA5A5_0001, r);
    check_res("b2b0", r, 0, 32'h2000_0030, 3'd2, 0, 32'hA5A5_0001, 0, 3, 1, 3'd4, 4'hF);
    xfer(0, 32'h2000_0034, 3'd2, 0, 0, 0, 0, 0, 32'hA5A5_0002, r);
    check_res("b2b1", r, 0, 32'h2000_0034, 3'd2, 0, 32'hA5A5_0002, 0, 3, 1, 3'd4, 4'hF);
    tick();

`ifdef AHB_TL_BRIDGE_POSTED_WRITE_EN
    // Posted write denied while a following read is held
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h2000_0040; hsize = 3'd2;
    tick();
    chk("pw_wdata_ready", 32'(hreadyout), 32'd1);
    hwdata = 32'h0BAD_F00D; hwrite = 1'b0; haddr = 32'h2000_0044;
    tick();
    bus_idle();
    chk("pw_a_valid", 32'({a_valid, hreadyout}), 32'b10);
    chk("pw_a_data", a_data, 32'h0BAD_F00D);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("pw_d_wait", 32'({d_ready, hreadyout}), 32'b10);
    d_valid = 1'b1; d_denied = 1'b1;
    tick();
    d_valid = 1'b0; d_denied = 1'b0;
    chk("pw_err_flag", 32'(posted_err), 32'd1);
    chk("pw_held_read", 32'({hreadyout, a_valid, a_opcode}), 32'b0_1_100);
    chk("pw_held_addr", a_address, 32'h2000_0044);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0; d_valid = 1'b1; d_data = 32'h600D_CAFE;
    tick();
    d_valid = 1'b0;
    chk("pw_read_resp", 32'({hreadyout, hresp}), 32'b10);
    chk("pw_read_data", hrdata, 32'h600D_CAFE);
    tick();
`endif

    // Randomized transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      bit w, bd, den, cor, tl_err, e_err;
      logic [2:0] sz;
      logic [31:0] addr, wd, dd;
      int aw, dw;
      w   = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      addr = 32'h2000_0000 | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      wd  = $urandom; dd = $urandom;
      aw  = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      den = ($urandom_range(0, 7) == 0);
      cor = ($urandom_range(0, 7) == 0);
      bd     = ref_bad(addr, sz);
      tl_err = den || (cor && !w);
      e_err  = bd || (tl_err && !(POSTED && w));
      xfer(w, addr, sz, wd, aw, dw, den, cor, dd, r);
      check_res($sformatf("rnd%0d", i), r, w, addr, sz, wd, dd, e_err,
                ref_cyc(w, bd, tl_err, aw, dw), !bd,
                w ? ((sz == 3'd2) ? 3'd0 : 3'd1) : 3'd4, ref_mask(addr, sz));
      if (e_err || $urandom_range(0, 1) == 0) tick();
    end
    tick();

    // Reset asserted in D_WAIT; a late D beat must be dropped
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h2000_0050; hsize = 3'd2;
    tick();
    bus_idle();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("rst_mid_d_ready", 32'(d_ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ahb", 32'({hreadyout, hresp}), 32'b10);
    chk("rst_mid_hrdata", hrdata, 32'd0);
    chk("rst_mid_a", 32'({a_valid, a_opcode, a_size, a_mask, d_ready, posted_err}), 32'd0);
    chk("rst_mid_addr", a_address, 32'd0);
    tick();
    reset = 1'b0;
    d_valid = 1'b1; d_data = 32'hBADD_BADD;
    tick();
    d_valid = 1'b0;
    chk("late_d_dropped", 32'({hreadyout, hresp, a_valid, d_ready}), 32'b1000);
    chk("late_d_hrdata", hrdata, 32'd0);
    tick();
    xfer(0, 32'h2000_0054, 3'd2, 0, 0, 0, 0, 0, 32'h0102_0304, r);
    check_res("post_rst", r, 0, 32'h2000_0054, 3'd2, 0, 32'h0102_0304, 0, 3, 1, 3'd4, 4'hF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
